// File: rtl/pkt_read_release_if.sv
// rtl/pkt_read_release_if.sv - descriptor, packet RAM, transmit and free-ID signals of the packet read side
interface pkt_read_release_if;
    logic [8:0]   desc_bufid;
    logic         desc_wr;
    logic         desc_ack;
    logic         pkt_ram_rd;
    logic [11:0]  pkt_ram_raddr;
    logic [133:0] pkt_ram_rdata;
    logic [133:0] pkt_data;
    logic         pkt_data_wr;
    logic         tx_afull;
    logic [8:0]   bufid_free_req;
    logic         bufid_free_req_wr;
    logic         bufid_free_req_ack;
    logic [7:0]   overrun_cnt;

    // Environment side: scheduler, packet RAM, transmit FIFO and buffer manager
    modport master (
        output desc_bufid, desc_wr, pkt_ram_rdata, tx_afull, bufid_free_req_ack,
        input  desc_ack, pkt_ram_rd, pkt_ram_raddr, pkt_data, pkt_data_wr,
               bufid_free_req, bufid_free_req_wr, overrun_cnt
    );

    // Read-release engine side
    modport slave (
        input  desc_bufid, desc_wr, pkt_ram_rdata, tx_afull, bufid_free_req_ack,
        output desc_ack, pkt_ram_rd, pkt_ram_raddr, pkt_data, pkt_data_wr,
               bufid_free_req, bufid_free_req_wr, overrun_cnt
    );
endinterface

// File: rtl/pkt_read_release.sv
// rtl/pkt_read_release.sv - streams one buffered packet out of the packet RAM and frees its buffer ID
module pkt_read_release #(
    parameter int RAM_RD_LAT    = 2,
    parameter int LINES_PER_BUF = 8
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    pkt_read_release_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_FREE} state_t;

    localparam logic [1:0] FLAG_TAIL = 2'b10;

    state_t                  state_q, state_d;
    logic [8:0]              bufid_q;
    logic [3:0]              issue_cnt_q;
    logic [2:0]              rcv_cnt_q;
    logic                    tail_seen_q;
    logic [RAM_RD_LAT-1:0]   vld_q;
    logic                    rd_q;
    logic [11:0]             raddr_q;
    logic                    desc_ack_q;
    logic [133:0]            pkt_data_q;
    logic                    pkt_data_wr_q;
    logic [8:0]              free_id_q;
    logic                    free_wr_q;
    logic [7:0]              overrun_q;

    logic                    accept;
    logic                    issue_en;
    logic                    ret_vld;
    logic                    ret_end;
    logic                    overrun_hit;
    logic                    pipe_empty;
    logic                    free_start;
    logic                    free_done;
    logic                    ret_last_line;

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: one packet at a time, the free handshake closes each packet
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.desc_wr)            state_d = S_READ;
            S_READ:  if (ret_end)                state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty)             state_d = S_FREE;
            S_FREE:  if (bus.bufid_free_req_ack) state_d = S_IDLE;
            default:                             state_d = S_IDLE;
        endcase
    end

    // Control strobes; the tail/last-line return both ends the packet and squashes the in-flight reads
    always_comb begin
        ret_last_line = (rcv_cnt_q == 3'(LINES_PER_BUF - 1));
        accept        = (state_q == S_IDLE) && bus.desc_wr;
        ret_vld       = vld_q[RAM_RD_LAT-1] && ((state_q == S_READ) || (state_q == S_DRAIN));
        ret_end       = ret_vld && (state_q == S_READ) &&
                        ((bus.pkt_ram_rdata[133:132] == FLAG_TAIL) || ret_last_line);
        overrun_hit   = ret_end && ret_last_line && (bus.pkt_ram_rdata[133:132] != FLAG_TAIL);
        issue_en      = (state_q == S_READ) && !bus.tx_afull && !tail_seen_q && !ret_end &&
                        (issue_cnt_q < 4'(LINES_PER_BUF));
        pipe_empty    = (vld_q == '0) && !rd_q;
        free_start    = (state_q == S_DRAIN) && pipe_empty;
        free_done     = (state_q == S_FREE) && bus.bufid_free_req_ack;
    end

    // Packet context: buffer ID, counters and tail flag, cleared on each accepted descriptor
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            bufid_q     <= '0;
            issue_cnt_q <= '0;
            rcv_cnt_q   <= '0;
            tail_seen_q <= 1'b0;
            desc_ack_q  <= 1'b0;
        end else begin
            desc_ack_q <= accept;
            if (accept) begin
                bufid_q     <= bus.desc_bufid;
                issue_cnt_q <= '0;
                rcv_cnt_q   <= '0;
                tail_seen_q <= 1'b0;
            end else begin
                if (issue_en) issue_cnt_q <= issue_cnt_q + 4'd1;
                if (ret_vld)  rcv_cnt_q   <= rcv_cnt_q + 3'd1;
                if (ret_end)  tail_seen_q <= 1'b1;
            end
        end
    end

    // Speculative read issue and the in-flight valid shift register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= 1'b0;
            raddr_q <= '0;
            vld_q   <= '0;
        end else begin
            rd_q <= issue_en;
            if (issue_en) raddr_q <= {bufid_q, issue_cnt_q[2:0]};
            // Reads already issued when the tail comes back carry data past the packet end
            if (ret_end) vld_q <= '0;
            else         vld_q <= {vld_q[RAM_RD_LAT-2:0], rd_q};
        end
    end

    // Output line register; a missing tail on the last line is patched to a tail flag
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pkt_data_q    <= '0;
            pkt_data_wr_q <= 1'b0;
            overrun_q     <= '0;
        end else begin
            pkt_data_wr_q <= ret_vld;
            if (ret_vld) begin
                pkt_data_q <= overrun_hit ? {FLAG_TAIL, bus.pkt_ram_rdata[131:0]} : bus.pkt_ram_rdata;
            end
            if (overrun_hit && (overrun_q != 8'hFF)) overrun_q <= overrun_q + 8'd1;
        end
    end

    // Free-ID request, held from pipeline empty until acknowledged
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            free_id_q <= '0;
            free_wr_q <= 1'b0;
        end else if (free_start) begin
            free_id_q <= bufid_q;
            free_wr_q <= 1'b1;
        end else if (free_done) begin
            free_wr_q <= 1'b0;
        end
    end

    assign bus.desc_ack          = desc_ack_q;
    assign bus.pkt_ram_rd        = rd_q;
    assign bus.pkt_ram_raddr     = raddr_q;
    assign bus.pkt_data          = pkt_data_q;
    assign bus.pkt_data_wr       = pkt_data_wr_q;
    assign bus.bufid_free_req    = free_id_q;
    assign bus.bufid_free_req_wr = free_wr_q;
    assign bus.overrun_cnt       = overrun_q;
endmodule

// File: tb/tb_pkt_read_release.sv
// tb/tb_pkt_read_release.sv - scoreboard bench for pkt_read_release
module tb_pkt_read_release;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;

    pkt_read_release_if bus();

    pkt_read_release #(.RAM_RD_LAT(2), .LINES_PER_BUF(8)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    int n_vec = 0;
    int n_bad = 0;
    int out_cnt = 0;
    int free_cnt = 0;
    int ack_delay = 0;
    logic [133:0] exp_q[$];
    logic [8:0]   free_q[$];
    logic [11:0]  rd_log[$];
    logic         prev_wr = 1'b0;
    logic         prev_ack = 1'b0;

    function automatic void chk(input string name, input logic [133:0] act, input logic [133:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Packet RAM model: two-cycle read latency, all-ones when no read is due
    logic [133:0] mem [0:4095];
    logic [11:0]  a1;
    logic         v1;
    always @(posedge clk_sys) begin
        v1 <= bus.pkt_ram_rd;
        a1 <= bus.pkt_ram_raddr;
        bus.pkt_ram_rdata <= v1 ? mem[a1] : {134{1'b1}};
    end

    // Buffer manager: acknowledges a pending free after ack_delay cycles
    initial begin
        bus.bufid_free_req_ack = 1'b0;
        forever begin
            @(posedge clk_sys); #1;
            if (bus.bufid_free_req_wr) begin
                repeat (ack_delay) begin @(posedge clk_sys); #1; end
                bus.bufid_free_req_ack = 1'b1;
                @(posedge clk_sys); #1;
                bus.bufid_free_req_ack = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT presents a line or completes a free
    always @(negedge clk_sys) begin
        if (reset_n) begin
            if (bus.pkt_ram_rd) rd_log.push_back(bus.pkt_ram_raddr);
            if (bus.pkt_data_wr) begin
                out_cnt++;
                if (exp_q.size() == 0) chk("extra_line", bus.pkt_data, {134{1'bx}});
                else                   chk("pkt_data", bus.pkt_data, exp_q.pop_front());
            end
            if (bus.bufid_free_req_wr && bus.bufid_free_req_ack) begin
                free_cnt++;
                if (free_q.size() == 0) chk("extra_free", 134'(bus.bufid_free_req), {134{1'bx}});
                else                    chk("free_id", 134'(bus.bufid_free_req), 134'(free_q.pop_front()));
            end
            if (prev_wr && !prev_ack) chk("free_wr_held", 134'(bus.bufid_free_req_wr), 134'(1));
            prev_wr  = bus.bufid_free_req_wr;
            prev_ack = bus.bufid_free_req_ack;
        end
    end

    // nl lines: 01, 11.., 10; nl == 0 builds an 8-line packet with no tail flag
    task automatic load_pkt(input logic [8:0] id, input int nl);
        for (int i = 0; i < 8; i++) begin
            logic [1:0]   f;
            logic [131:0] pl;
            pl = {8'hA5, 112'h0, id, 3'(i)};
            if (nl == 0)           f = 2'b11;
            else if (i == 0)       f = 2'b01;
            else if (i == nl - 1)  f = 2'b10;
            else if (i < nl - 1)   f = 2'b11;
            else                   f = 2'b01;
            mem[{id, 3'(i)}] = {f, pl};
            if (nl == 0 || i < nl) exp_q.push_back({(nl == 0 && i == 7) ? 2'b10 : f, pl});
        end
        free_q.push_back(id);
    endtask

    task automatic send_desc(input logic [8:0] id, input bit chk_first);
        int t;
        t = 0;
        bus.desc_bufid = id;
        bus.desc_wr    = 1'b1;
        @(negedge clk_sys);
        while (bus.desc_ack !== 1'b1 && t < 300) begin
            @(negedge clk_sys);
            t++;
        end
        chk("desc_ack", 134'(bus.desc_ack), 134'(1));
        bus.desc_wr = 1'b0;
        if (chk_first) begin
            @(negedge clk_sys);
            chk("first_rd", 134'({bus.pkt_ram_rd, bus.pkt_ram_raddr}), 134'({1'b1, id, 3'b000}));
        end
    endtask

    task automatic wait_frees(input int target);
        int t;
        t = 0;
        while (free_cnt < target && t < 500) begin
            @(posedge clk_sys);
            t++;
        end
        #1;
        chk("free_count", 134'(free_cnt), 134'(target));
        chk("lines_left", 134'(exp_q.size()), 134'(0));
    endtask

    task automatic chk_outs_zero(input string name);
        chk({name, "_data"}, bus.pkt_data, 134'h0);
        chk({name, "_ctl"}, 134'({bus.desc_ack, bus.pkt_ram_rd, bus.pkt_ram_raddr, bus.pkt_data_wr,
                                  bus.bufid_free_req, bus.bufid_free_req_wr, bus.overrun_cnt}), 134'h0);
    endtask

    initial begin
        int c0, c1, r0, t;
        bus.desc_bufid = '0;
        bus.desc_wr    = 1'b0;
        bus.tx_afull   = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_outs_zero("reset");
        reset_n = 1'b1;
        @(negedge clk_sys);

        // Normal 3-line packet: two speculative reads, three lines out
        rd_log.delete();
        load_pkt(9'd5, 3);
        send_desc(9'd5, 1'b1);
        wait_frees(1);
        chk("norm_rd_count", 134'(rd_log.size()), 134'(5));
        for (int i = 0; i < 5; i++) chk("norm_raddr", 134'(rd_log[i]), 134'(12'h028 + 12'(i)));

        // Overrun: no tail within 8 lines
        rd_log.delete();
        load_pkt(9'd511, 0);
        send_desc(9'd511, 1'b1);
        wait_frees(2);
        chk("ovr_cnt", 134'(bus.overrun_cnt), 134'(1));
        chk("ovr_rd_count", 134'(rd_log.size()), 134'(8));
        chk("ovr_last_raddr", 134'(rd_log[7]), 134'(12'hFFF));

        // Backpressure mid-packet on an 8-line packet whose tail is on line 7
        load_pkt(9'd100, 8);
        send_desc(9'd100, 1'b1);
        repeat (2) @(negedge clk_sys);
        bus.tx_afull = 1'b1;
        @(posedge clk_sys);
        @(posedge clk_sys);
        #1;
        c0 = out_cnt;
        r0 = rd_log.size();
        repeat (8) @(posedge clk_sys);
        #1;
        c1 = out_cnt;
        chk("afull_drain_le2", 134'(c1 - c0 <= 2), 134'(1));
        chk("afull_no_issue", 134'(rd_log.size() - r0), 134'(0));
        @(negedge clk_sys);
        bus.tx_afull = 1'b0;
        wait_frees(3);
        chk("tail_l7_no_ovr", 134'(bus.overrun_cnt), 134'(1));

        // Delayed free ack with a descriptor waiting behind it
        ack_delay = 20;
        load_pkt(9'd7, 2);
        send_desc(9'd7, 1'b1);
        t = 0;
        while (bus.bufid_free_req_wr !== 1'b1 && t < 100) begin
            @(posedge clk_sys); #1;
            t++;
        end
        chk("free_wr_rise", 134'(bus.bufid_free_req_wr), 134'(1));
        load_pkt(9'd8, 2);
        send_desc(9'd8, 1'b0);
        chk("ack_after_free", 134'(free_cnt), 134'(4));
        ack_delay = 0;
        wait_frees(5);

        // Back-to-back descriptors
        load_pkt(9'd3, 2);
        load_pkt(9'd4, 2);
        send_desc(9'd3, 1'b1);
        send_desc(9'd4, 1'b0);
        wait_frees(7);

        // Reset while line 2 is in flight, then a normal packet
        load_pkt(9'd20, 6);
        c0 = out_cnt;
        send_desc(9'd20, 1'b1);
        t = 0;
        while (out_cnt < c0 + 2 && t < 100) begin
            @(posedge clk_sys);
            t++;
        end
        chk("pre_reset_lines", 134'(out_cnt - c0), 134'(2));
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        free_q.delete();
        #1;
        chk_outs_zero("mid_reset");
        @(negedge clk_sys);
        chk_outs_zero("mid_reset_hold");
        reset_n = 1'b1;
        @(negedge clk_sys);
        load_pkt(9'd21, 3);
        send_desc(9'd21, 1'b1);
        wait_frees(8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
